// File: rtl/bnn_conv_calc_tm.sv
// rtl/bnn_conv_calc_tm.sv - time-multiplexed XNOR-popcount conv engine with runtime weights/thresholds
// Optional: BNN_POLARITY_EN adds a per-channel output polarity bit (cfg_flip).
module bnn_conv_calc_tm #(
  parameter int WIN_BITS   = 72,
  parameter int OUT_CH     = 16,
  parameter int LANES      = 4,
  parameter int THRESH_DEF = 36,
  parameter int CNT_W      = $clog2(WIN_BITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [$clog2(OUT_CH)-1:0] cfg_ch,
  input  logic [WIN_BITS-1:0]       cfg_weight,
  input  logic [CNT_W-1:0]          cfg_thresh,
`ifdef BNN_POLARITY_EN
  input  logic                      cfg_flip,
`endif
  output logic                      cfg_ready,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIN_BITS-1:0]       pixel_windows,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_CH-1:0]         conv_out,
  output logic                      busy
);

  localparam int CH_W   = $clog2(OUT_CH);
  localparam int GROUPS = OUT_CH / LANES;
  localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

  state_t              state_q, state_d;
  logic [G_W-1:0]      g_q, g_d;
  logic [WIN_BITS-1:0] win_q, win_d;
  logic [OUT_CH-1:0]   result_q, result_d;
  logic                live_q, live_d;
  logic [WIN_BITS-1:0] weight_q [OUT_CH];
  logic [WIN_BITS-1:0] weight_d [OUT_CH];
  logic [CNT_W-1:0]    thresh_q [OUT_CH];
  logic [CNT_W-1:0]    thresh_d [OUT_CH];
`ifdef BNN_POLARITY_EN
  logic [OUT_CH-1:0]   flip_q, flip_d;
`endif

  logic [CH_W-1:0]     lane_ch  [LANES];
  logic [CNT_W-1:0]    lane_cnt [LANES];
  logic [LANES-1:0]    lane_bit;
  logic                cfg_acc;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIN_BITS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIN_BITS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // live_q keeps the handshake outputs low until the first clock after reset release
  assign in_ready  = live_q && (state_q == S_IDLE);
  assign cfg_ready = in_ready;
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q == S_CALC) || (state_q == S_OUT);
  assign conv_out  = out_valid ? result_q : '0;
  assign cfg_acc   = cfg_we && cfg_ready;

  always_comb begin
    lane_bit = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_ch[l]  = CH_W'(int'(g_q) * LANES + l);
      lane_cnt[l] = popcount(~(win_q ^ weight_q[lane_ch[l]]));
`ifdef BNN_POLARITY_EN
      lane_bit[l] = flip_q[lane_ch[l]] ? (lane_cnt[l] <  thresh_q[lane_ch[l]])
                                       : (lane_cnt[l] >= thresh_q[lane_ch[l]]);
`else
      lane_bit[l] = (lane_cnt[l] >= thresh_q[lane_ch[l]]);
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    win_d    = win_q;
    result_d = result_q;
    live_d   = 1'b1;
    weight_d = weight_q;
    thresh_d = thresh_q;
`ifdef BNN_POLARITY_EN
    flip_d   = flip_q;
`endif
    // Out-of-range channel indices match no entry and are dropped
    for (int c = 0; c < OUT_CH; c++) begin
      if (cfg_acc && (cfg_ch == CH_W'(c))) begin
        weight_d[c] = cfg_weight;
        thresh_d[c] = cfg_thresh;
`ifdef BNN_POLARITY_EN
        flip_d[c]   = cfg_flip;
`endif
      end
    end
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d  = S_CALC;
          win_d    = pixel_windows;
          result_d = '0;
          g_d      = '0;
        end
      end
      S_CALC: begin
        for (int l = 0; l < LANES; l++) result_d[lane_ch[l]] = lane_bit[l];
        if (g_q == G_W'(GROUPS - 1)) begin
          state_d = S_OUT;
          g_d     = '0;
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      g_q      <= '0;
      win_q    <= '0;
      result_q <= '0;
      live_q   <= 1'b0;
      for (int c = 0; c < OUT_CH; c++) begin
        weight_q[c] <= '0;
        thresh_q[c] <= CNT_W'(THRESH_DEF);
      end
`ifdef BNN_POLARITY_EN
      flip_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      win_q    <= win_d;
      result_q <= result_d;
      live_q   <= live_d;
      weight_q <= weight_d;
      thresh_q <= thresh_d;
`ifdef BNN_POLARITY_EN
      flip_q   <= flip_d;
`endif
    end
  end

endmodule

// File: tb/tb_bnn_conv_calc_tm.sv
// tb/tb_bnn_conv_calc_tm.sv - directed table-driven bench for bnn_conv_calc_tm
// Polarity checks are compiled in when BNN_POLARITY_EN is defined.
module tb_bnn_conv_calc_tm;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [71:0] cfg_weight;
  logic [6:0]  cfg_thresh;
`ifdef BNN_POLARITY_EN
  logic        cfg_flip;
`endif
  logic        cfg_ready;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] pixel_windows;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] conv_out;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  bnn_conv_calc_tm dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_weight(cfg_weight), .cfg_thresh(cfg_thresh),
`ifdef BNN_POLARITY_EN
    .cfg_flip(cfg_flip),
`endif
    .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_windows(pixel_windows),
    .out_valid(out_valid), .out_ready(out_ready), .conv_out(conv_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_cfg;
    logic [3:0]  ch;
    logic [71:0] w;
    logic [6:0]  t;
    logic [71:0] win;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cfg_write(input logic [3:0] ch, input logic [71:0] w, input logic [6:0] t);
    cfg_we = 1'b1; cfg_ch = ch; cfg_weight = w; cfg_thresh = t;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Caller has in_valid (and optionally cfg_we) set up; counts edges to out_valid, then handshakes.
  task automatic wait_out(output logic [15:0] res, output int lat);
    lat = -1; res = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; cfg_we = 1'b0;
      if (out_valid) begin lat = i; res = conv_out; break; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_window(input logic [71:0] win, output logic [15:0] res, output int lat);
    in_valid = 1'b1; pixel_windows = win;
    wait_out(res, lat);
  endtask

  logic [71:0] all1, half, w37;
  logic [15:0] res, first;
  int lat;
  logic stable;

  initial begin
    all1 = {72{1'b1}};
    half = {{36{1'b1}}, {36{1'b0}}};
    w37  = {{35{1'b0}}, {37{1'b1}}};
    vecs[0] = '{1'b1, 4'd0,  all1, 7'd36, all1,  16'h0001};
    vecs[1] = '{1'b0, 4'd0,  '0,   7'd0,  '0,    16'hFFFE};
    vecs[2] = '{1'b1, 4'd3,  '0,   7'd36, half,  16'hFFFF};
    vecs[3] = '{1'b1, 4'd3,  '0,   7'd37, half,  16'hFFF7};
    vecs[4] = '{1'b1, 4'd7,  '0,   7'd0,  all1,  16'h0081};
    vecs[5] = '{1'b1, 4'd9,  '0,   7'd73, '0,    16'hFDFE};
    vecs[6] = '{1'b1, 4'd12, '0,   7'd72, 72'h1, 16'hEDFE};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_weight = '0; cfg_thresh = '0;
`ifdef BNN_POLARITY_EN
    cfg_flip = 1'b0;
`endif
    in_valid = 1'b0; pixel_windows = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_cfg_ready", cfg_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_conv_out", conv_out, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_cfg_ready", cfg_ready, 1);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_cfg) cfg_write(vecs[i].ch, vecs[i].w, vecs[i].t);
      run_window(vecs[i].win, res, lat);
      chk($sformatf("vec%0d_latency", i), lat, 5);
      chk($sformatf("vec%0d_conv_out", i), res, vecs[i].exp);
    end

    // Config write during CALC is dropped
    in_valid = 1'b1; pixel_windows = all1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_ch = 4'd5; cfg_weight = all1; cfg_thresh = 7'd36;
    #1;
    chk("calc_cfg_ready", cfg_ready, 0);
    wait_out(res, lat);
    run_window(all1, res, lat);
    chk("calc_cfg_dropped", res, 16'h0081);
    cfg_write(4'd5, all1, 7'd36);
    run_window(all1, res, lat);
    chk("idle_cfg_applied", res, 16'h00A1);

    // Downstream stall holds the result
    in_valid = 1'b1; pixel_windows = all1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) begin lat = i; break; end
    end
    chk("stall_latency", lat, 5);
    first = conv_out;
    chk("stall_value", first, 16'h00A1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (conv_out !== first || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1)
        stable = 1'b0;
    end
    chk("stall_hold", stable, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_release_in_ready", in_ready, 1);
    chk("stall_release_out_valid", out_valid, 0);
    chk("stall_release_conv_out", conv_out, 0);

    // Reset mid-CALC restores defaults
    in_valid = 1'b1; pixel_windows = all1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_conv_out", conv_out, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_in_ready", in_ready, 1);
    run_window('0, res, lat);
    chk("after_reset_latency", lat, 5);
    chk("after_reset_defaults", res, 16'hFFFF);

    // Same-cycle config write and window accept: window sees the new weight
    cfg_we = 1'b1; cfg_ch = 4'd2; cfg_weight = all1; cfg_thresh = 7'd36;
    in_valid = 1'b1; pixel_windows = all1;
    wait_out(res, lat);
    chk("same_cycle_latency", lat, 5);
    chk("same_cycle_cfg_first", res, 16'h0004);

`ifdef BNN_POLARITY_EN
    cfg_flip = 1'b1;
    cfg_write(4'd0, '0, 7'd36);
    cfg_flip = 1'b0;
    run_window('0, res, lat);
    chk("flip_cnt72", res[0], 0);
    run_window(w37, res, lat);
    chk("flip_cnt35", res[0], 1);
`else
    run_window(w37, res, lat);
    chk("noflip_cnt35", res[0], 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
